// File: rtl/fill_sequencer.sv
// fill_sequencer: writes a fill pattern over an address range as ready/valid beats, with abort support
module fill_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic [DATA_W-1:0] cmd_const,
  input  logic              abort,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_oe,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [ADDR_W:0]   words_written
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state, state_nxt;
  logic [1:0] mode;
  logic [DATA_W-1:0] fill_const;
  logic [ADDR_W:0] remaining;
  logic accept, beat, last;
  assign accept = cmd_valid && cmd_ready;
  assign beat = wr_valid && wr_ready;
  assign last = beat && (remaining == (ADDR_W+1)'(1));
  // State register; reset returns to IDLE at the edge
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Next state: an empty command skips straight to DONE; abort or the final beat ends WRITE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? ((cmd_count == '0) ? DONE : WRITE) : IDLE;
      WRITE:   state_nxt = (abort || last) ? DONE : WRITE;
      default: state_nxt = IDLE;
    endcase
  end
  // Outputs decoded from state; data is forced to zero outside WRITE and in bus-release mode
  always_comb begin
    cmd_ready = rst_n && (state == IDLE);
    wr_valid = (state == WRITE);
    busy = (state == WRITE);
    done = (state == DONE);
    wr_oe = wr_valid && (mode != 2'd3);
    wr_data = !wr_valid ? '0 : (mode == 2'd1) ? '1 : (mode == 2'd2) ? fill_const : '0;
  end
  // Command capture and per-beat address/count bookkeeping; a beat coinciding with abort still counts
  always_ff @(posedge clk)
    if (!rst_n) begin
      mode <= '0;
      fill_const <= '0;
      remaining <= '0;
      wr_addr <= '0;
      words_written <= '0;
      aborted <= 1'b0;
    end else if (accept) begin
      mode <= cmd_mode;
      fill_const <= cmd_const;
      remaining <= cmd_count;
      wr_addr <= cmd_base;
      words_written <= '0;
      aborted <= 1'b0;
    end else if (state == WRITE) begin
      if (beat) begin
        wr_addr <= wr_addr + 1'b1;
        words_written <= words_written + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (abort) aborted <= !last;
    end
endmodule

// File: tb/tb_fill_sequencer.sv
// tb_fill_sequencer: directed self-checking bench for fill_sequencer
module tb_fill_sequencer;
  logic clk = 1'b0;
  logic rst_n, cmd_valid, cmd_ready, abort, wr_valid, wr_ready, wr_oe, busy, done, aborted;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_base, wr_addr;
  logic [8:0] cmd_count, words_written;
  logic [31:0] cmd_const, wr_data;
  int tests = 0;
  int fails = 0;

  fill_sequencer #(.DATA_W(32), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_const(cmd_const),
    .abort(abort), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_oe(wr_oe), .busy(busy), .done(done), .aborted(aborted),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [7:0] b, input logic [8:0] c, input logic [31:0] k);
    cmd_valid = 1'b1;
    cmd_mode = m;
    cmd_base = b;
    cmd_count = c;
    cmd_const = k;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] ea;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_base = '0; cmd_count = '0;
    cmd_const = '0; abort = 1'b0; wr_ready = 1'b0;
    tick();
    tick();
    check("rst cmd_ready", cmd_ready, 0);
    check("rst wr_valid", wr_valid, 0);
    check("rst wr_oe", wr_oe, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst aborted", aborted, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst words", words_written, 0);
    rst_n = 1'b1;
    #1;
    check("post-rst cmd_ready", cmd_ready, 1);

    // mode 1, base 0x10, count 4, always ready: accept is cycle 1, beats 2..5, done cycle 6
    wr_ready = 1'b1;
    issue(2'd1, 8'h10, 9'd4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("m1 valid", wr_valid, 1);
      check("m1 busy", busy, 1);
      check("m1 ready low", cmd_ready, 0);
      check("m1 addr", wr_addr, 64'(8'h10 + i));
      check("m1 data", wr_data, 32'hFFFF_FFFF);
      check("m1 oe", wr_oe, 1);
      check("m1 done low", done, 0);
      tick();
    end
    check("m1 done", done, 1);
    check("m1 aborted", aborted, 0);
    check("m1 words", words_written, 4);
    check("m1 valid off", wr_valid, 0);
    check("m1 no accept in done", cmd_ready, 0);
    tick();
    check("m1 done pulse", done, 0);
    check("m1 idle ready", cmd_ready, 1);
    check("m1 words hold", words_written, 4);

    // mode 2 constant across the top of the address space, stalling each beat one cycle
    wr_ready = 1'b0;
    issue(2'd2, 8'hFE, 9'd3, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      ea = 8'hFE + 8'(i);
      check("m2 valid", wr_valid, 1);
      check("m2 addr", wr_addr, ea);
      check("m2 data", wr_data, 32'hDEAD_BEEF);
      tick();
      check("m2 stall addr", wr_addr, ea);
      check("m2 stall data", wr_data, 32'hDEAD_BEEF);
      check("m2 stall oe", wr_oe, 1);
      check("m2 stall words", words_written, 9'(i));
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
    end
    check("m2 done", done, 1);
    check("m2 words", words_written, 3);
    tick();

    // mode 3 bus release
    wr_ready = 1'b1;
    issue(2'd3, 8'h33, 9'd2, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      check("m3 valid", wr_valid, 1);
      check("m3 oe", wr_oe, 0);
      check("m3 data", wr_data, 0);
      tick();
    end
    check("m3 done", done, 1);
    check("m3 words", words_written, 2);
    tick();

    // empty command
    issue(2'd0, 8'h44, 9'd0, 32'h0);
    check("c0 done", done, 1);
    check("c0 valid", wr_valid, 0);
    check("c0 words", words_written, 0);
    check("c0 aborted", aborted, 0);
    tick();
    check("c0 idle", cmd_ready, 1);

    // abort with the 3rd beat of 8
    issue(2'd0, 8'h00, 9'd8, 32'h0);
    tick();
    tick();
    check("ab addr3", wr_addr, 2);
    check("ab words before", words_written, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab done", done, 1);
    check("ab aborted", aborted, 1);
    check("ab words", words_written, 3);
    check("ab valid off", wr_valid, 0);
    tick();
    check("ab words hold", words_written, 3);

    // abort held through accept is ignored; abort on the final beat is a normal finish
    abort = 1'b1;
    issue(2'd1, 8'h80, 9'd2, 32'h0);
    abort = 1'b0;
    check("abl started", wr_valid, 1);
    tick();
    check("abl 2nd addr", wr_addr, 8'h81);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abl done", done, 1);
    check("abl aborted", aborted, 0);
    check("abl words", words_written, 2);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort idle ignored", cmd_ready, 1);

    // reset during the 2nd beat of a 5-word fill
    issue(2'd1, 8'h20, 9'd5, 32'h0);
    tick();
    check("rw addr2", wr_addr, 8'h21);
    rst_n = 1'b0;
    tick();
    check("rw valid", wr_valid, 0);
    check("rw oe", wr_oe, 0);
    check("rw busy", busy, 0);
    check("rw done", done, 0);
    check("rw aborted", aborted, 0);
    check("rw ready", cmd_ready, 0);
    check("rw addr", wr_addr, 0);
    check("rw data", wr_data, 0);
    check("rw words", words_written, 0);
    rst_n = 1'b1;
    #1;
    check("rw ready after", cmd_ready, 1);
    tick();
    check("rw no done", done, 0);

    // full 256-word wrap
    issue(2'd2, 8'h40, 9'd256, 32'h0000_0005);
    for (int i = 0; i < 256; i++) begin
      ea = 8'h40 + 8'(i);
      check("w256 addr", {wr_valid, wr_addr}, {1'b1, ea});
      tick();
    end
    check("w256 done", done, 1);
    check("w256 words", words_written, 256);
    check("w256 last addr", wr_addr, 8'h40);
    check("w256 aborted", aborted, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
